// File: rtl/mm_pkg.sv
// Shared types and helpers for the Montgomery multiplier BRAM port.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_LOAD  = 1'b0;
    localparam logic MODE_STORE = 1'b1;

    // Word index to byte address shift for a BRAM of the given data width.
    function automatic int byte_shift(input int bram_width);
        return $clog2(bram_width / 8);
    endfunction

endpackage

// File: rtl/mm_skid_fifo.sv
// Small register-array FIFO absorbing in-flight BRAM reads; occupancy feeds the read-credit check.
module mm_skid_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 3,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [OCC_W-1:0] occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: the storage array has no reset; only pointers and occupancy define what is valid.
    always_ff @(posedge clock_i) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign empty     = (occ == '0);
    assign occupancy = occ;

endmodule

// File: rtl/mm_bram_port.sv
// BRAM master port moving limb runs between a BRAM controller and the multiplier streams.
// Optional overflow check on loaded words is built when MM_BRAM_PORT_OVF_CHECK_EN is defined.
module mm_bram_port
    import mm_pkg::*;
#(
    parameter int WORD_WIDTH   = 17,
    parameter int BRAM_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_LIMBS    = 64,
    localparam int CNT_W       = $clog2(MAX_LIMBS + 1)
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic                    mode_i,
    input  logic [ADDR_WIDTH-1:0]   base_i,
    input  logic [CNT_W-1:0]        count_i,
    output logic [WORD_WIDTH-1:0]   limb_o,
    output logic                    limb_valid_o,
    input  logic                    limb_ready_i,
    input  logic [WORD_WIDTH-1:0]   limb_i,
    input  logic                    limb_valid_i,
    output logic                    limb_ready_o,
    input  logic [BRAM_WIDTH-1:0]   BRAM_dout_i,
    output logic [BRAM_WIDTH-1:0]   BRAM_din_o,
    output logic [BRAM_WIDTH/8-1:0] BRAM_we_o,
    output logic [ADDR_WIDTH-1:0]   BRAM_addr_o,
    output logic                    BRAM_en_o,
    output logic                    BRAM_clock_o,
    output logic                    BRAM_reset_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o
);

    localparam int DEPTH = READ_LATENCY + 2;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int SHIFT = byte_shift(BRAM_WIDTH);

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        index_q;
    logic [CNT_W-1:0]        served_q;
    logic [READ_LATENCY-1:0] vld_q;
    logic                    wr_en_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [BRAM_WIDTH-1:0]   wr_din_q;

    logic [ADDR_WIDTH-1:0]   addr_cur;
    logic [OCC_W-1:0]        out_cnt;
    logic [OCC_W-1:0]        occ;
    logic [OCC_W:0]          credit_used;
    logic                    rd_en;
    logic                    push;
    logic                    pop;
    logic                    st_hs;
    logic                    fifo_empty;
    logic [WORD_WIDTH-1:0]   fifo_head;

    assign addr_cur = (base_q + ADDR_WIDTH'(index_q)) << SHIFT;
    assign push     = vld_q[READ_LATENCY-1];
    assign pop      = (state == LOAD) && !fifo_empty && limb_ready_i;
    assign st_hs    = (state == STORE) && limb_valid_i && limb_ready_o;

    // Reads in flight plus buffered limbs must never exceed the FIFO depth.
    always_comb begin
        out_cnt = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            out_cnt = out_cnt + OCC_W'(vld_q[i]);
        end
        credit_used = {1'b0, out_cnt} + {1'b0, occ};
        rd_en = (state == LOAD) && (index_q < count_q) && (credit_used < (OCC_W + 1)'(DEPTH));
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    if (count_i == '0)            state_nxt = DONE;
                    else if (mode_i == MODE_STORE) state_nxt = STORE;
                    else                           state_nxt = LOAD;
                end
            end
            LOAD:    if (pop && (served_q == count_q - CNT_W'(1))) state_nxt = DONE;
            STORE:   if (wr_en_q && (index_q == count_q))          state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state     <= IDLE;
            base_q    <= '0;
            count_q   <= '0;
            index_q   <= '0;
            served_q  <= '0;
            vld_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_din_q  <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && start_i) begin
                base_q   <= base_i;
                count_q  <= count_i;
                index_q  <= '0;
                served_q <= '0;
            end else begin
                if (rd_en || st_hs) index_q  <= index_q + CNT_W'(1);
                if (pop)            served_q <= served_q + CNT_W'(1);
            end
            vld_q[0] <= rd_en;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            wr_en_q <= st_hs;
            if (st_hs) begin
                wr_addr_q <= addr_cur;
                wr_din_q  <= BRAM_WIDTH'(limb_i);
            end
        end
    end

    mm_skid_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .push      (push),
        .push_data (BRAM_dout_i[WORD_WIDTH-1:0]),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .occupancy (occ)
    );

`ifdef MM_BRAM_PORT_OVF_CHECK_EN
    localparam logic [BRAM_WIDTH-1:0] HI_MASK = {BRAM_WIDTH{1'b1}} << WORD_WIDTH;
    logic error_q;

    always_ff @(posedge clock_i) begin
        if (!reset_i)                                         error_q <= 1'b0;
        else if (push && ((BRAM_dout_i & HI_MASK) != '0))     error_q <= 1'b1;
    end

    assign error_o = error_q;
`else
    logic unused_dout_hi;
    assign unused_dout_hi = ^BRAM_dout_i;
    assign error_o        = 1'b0;
`endif

    assign limb_valid_o = !fifo_empty;
    assign limb_o       = fifo_empty ? '0 : fifo_head;
    assign limb_ready_o = (state == STORE) && (index_q < count_q);
    assign BRAM_en_o    = rd_en || wr_en_q;
    assign BRAM_we_o    = wr_en_q ? '1 : '0;
    assign BRAM_din_o   = wr_en_q ? wr_din_q : '0;
    assign BRAM_addr_o  = rd_en ? addr_cur : (wr_en_q ? wr_addr_q : '0);
    assign BRAM_clock_o = clock_i;
    assign BRAM_reset_o = ~reset_i;
    assign busy_o       = (state != IDLE);
    assign done_o       = (state == DONE);

endmodule
